axis_packet_arbiter: RTL

//  Packet-granular N:1 AXI-stream arbiter. Shares one downstream stream (e.g. a splitter input) between
//  N requesting streams; a grant is held from the first beat to the tlast beat, so packets never interleave.

---
 rtl/axis_packet_arbiter_if.sv | 33 +++
 rtl/axis_packet_arbiter.sv | 115 +++++++++++
 2 files changed

// File: rtl/axis_packet_arbiter_if.sv
// Stream bundle for axis_packet_arbiter: N packed request streams in, one muxed stream out.
// slave is the arbiter's view; master is the view of whatever drives the requests and sinks the output.
interface axis_packet_arbiter_if #(
    parameter int AXIS_BYTES     = 1,
    parameter int AXIS_USER_BITS = 1,
    parameter int NUM_INPUTS     = 2
);
    localparam int DW = AXIS_BYTES * 8;
    localparam int UW = AXIS_USER_BITS;
    localparam int IW = (NUM_INPUTS < 2) ? 1 : $clog2(NUM_INPUTS);

    logic [NUM_INPUTS*DW-1:0] axis_i_tdata;
    logic [NUM_INPUTS*UW-1:0] axis_i_tuser;
    logic [NUM_INPUTS-1:0]    axis_i_tlast;
    logic [NUM_INPUTS-1:0]    axis_i_tvalid;
    logic [NUM_INPUTS-1:0]    axis_i_tready;
    logic [DW-1:0]            axis_o_tdata;
    logic [UW-1:0]            axis_o_tuser;
    logic                     axis_o_tlast;
    logic                     axis_o_tvalid;
    logic                     axis_o_tready;
    logic [IW-1:0]            axis_o_tid;

    modport slave (
        input  axis_i_tdata, axis_i_tuser, axis_i_tlast, axis_i_tvalid, axis_o_tready,
        output axis_i_tready, axis_o_tdata, axis_o_tuser, axis_o_tlast, axis_o_tvalid, axis_o_tid
    );

    modport master (
        output axis_i_tdata, axis_i_tuser, axis_i_tlast, axis_i_tvalid, axis_o_tready,
        input  axis_i_tready, axis_o_tdata, axis_o_tuser, axis_o_tlast, axis_o_tvalid, axis_o_tid
    );
endinterface

// File: rtl/axis_packet_arbiter.sv
// Packet-granular N:1 AXI-stream arbiter: grant is held from first beat to tlast, round-robin by default.
// Define AXIS_ARB_STRICT_PRIORITY_EN to select the lowest-index valid input instead of rotating.
module axis_packet_arbiter #(
    parameter int AXIS_BYTES     = 1,
    parameter int AXIS_USER_BITS = 1,
    parameter int NUM_INPUTS     = 2
) (
    input  logic                   clk,
    input  logic                   sresetn,
    axis_packet_arbiter_if.slave   bus
);
    localparam int DW = AXIS_BYTES * 8;
    localparam int UW = AXIS_USER_BITS;
    localparam int IW = (NUM_INPUTS < 2) ? 1 : $clog2(NUM_INPUTS);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [IW-1:0] grant_q, grant_d;
    logic [IW-1:0] scan_base_s;
    logic [IW-1:0] winner_s;
    logic          found_s;
    logic          hit_s;
    logic          locked_s;
    logic          last_beat_s;

`ifdef AXIS_ARB_STRICT_PRIORITY_EN
    // Scanning from N-1 makes input 0 the first candidate every time.
    assign scan_base_s = IW'(NUM_INPUTS - 1);
`else
    logic [IW-1:0] last_grant_q, last_grant_d;
    assign scan_base_s = last_grant_q;
`endif

    assign locked_s = sresetn & (state_q == ST_LOCKED);

    // Winner: first valid input after scan_base_s, wrapping modulo NUM_INPUTS.
    always_comb begin
        winner_s = {IW{1'b0}};
        found_s  = 1'b0;
        hit_s    = 1'b0;
        for (int off = 1; off <= NUM_INPUTS; off++) begin
            int idx;
            idx      = (int'(scan_base_s) + off) % NUM_INPUTS;
            hit_s    = bus.axis_i_tvalid[idx] & ~found_s;
            winner_s = hit_s ? IW'(idx) : winner_s;
            found_s  = found_s | bus.axis_i_tvalid[idx];
        end
    end

    // Output mux follows the grant in every state; only tvalid and tready are gated by the lock.
    always_comb begin
        bus.axis_o_tdata  = bus.axis_i_tdata[int'(grant_q)*DW +: DW];
        bus.axis_o_tuser  = bus.axis_i_tuser[int'(grant_q)*UW +: UW];
        bus.axis_o_tlast  = bus.axis_i_tlast[int'(grant_q)];
        bus.axis_o_tvalid = locked_s & bus.axis_i_tvalid[int'(grant_q)];
        bus.axis_o_tid    = grant_q;
        bus.axis_i_tready = {NUM_INPUTS{1'b0}};
        for (int k = 0; k < NUM_INPUTS; k++) begin
            bus.axis_i_tready[k] = locked_s & (grant_q == IW'(k)) & bus.axis_o_tready;
        end
    end

    assign last_beat_s = bus.axis_o_tvalid & bus.axis_o_tready & bus.axis_o_tlast;

    // IDLE picks a winner (one bubble cycle); LOCKED holds the grant until the tlast beat transfers.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
`ifndef AXIS_ARB_STRICT_PRIORITY_EN
        last_grant_d = last_grant_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (found_s) begin
                    state_d = ST_LOCKED;
                    grant_d = winner_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOCKED: begin
                if (last_beat_s) begin
                    state_d = ST_IDLE;
`ifndef AXIS_ARB_STRICT_PRIORITY_EN
                    last_grant_d = grant_q;
`endif
                end else begin
                    state_d = ST_LOCKED;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; last_grant resets to N-1 so rotation starts at input 0.
    always_ff @(posedge clk) begin
        if (!sresetn) begin
            state_q      <= ST_IDLE;
            grant_q      <= {IW{1'b0}};
`ifndef AXIS_ARB_STRICT_PRIORITY_EN
            last_grant_q <= IW'(NUM_INPUTS - 1);
`endif
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
`ifndef AXIS_ARB_STRICT_PRIORITY_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end
endmodule
